cpu_exec_ctrl: RTL and testbench
================================

Name: cpu_exec_ctrl

Overview:
- Execution sequencer for the single-cycle RISC-V datapath.
- Generates the commit enable that gates PC update and register-file/data-memory writes.
- Waits out the synchronous instruction-ROM latency after every PC change.
- Provides run/step/halt control, one PC breakpoint, ECALL stop, and cycle/instruction counters for the board debug display.

Parameters:
FETCH_WAIT, 1, cycles spent in FETCH before the instruction is evaluated (range 1..15)
START_RUNNING, 0, 1 = enter FETCH in RUN mode directly out of reset
ECALL_WORD, 32'h0000_0073, instruction encoding that stops execution

Ports:
iCLK  in  1  system clock; all state updates on rising edge
iRST  in  1  asynchronous, active-low reset
iRun  in  1  level; rising edge requests continuous run
iStep  in  1  level; rising edge requests exactly one instruction
iHalt  in  1  level; rising edge requests stop
iBreakEn  in  1  breakpoint enable
iBreakAddr  in  32  breakpoint PC
iPC  in  32  current PC from the datapath
iInstruction  in  32  ROM output for iPC
oCpuEn  out  1  commit enable; datapath updates PC, registers and memory only when high
oState  out  2  0=HALTED, 1=FETCH, 2=EXEC, 3=DONE
oBreakHit  out  1  halted by breakpoint
oDone  out  1  stopped by ECALL
oCycleCount  out  32  cycles spent in FETCH or EXEC
oInstrCount  out  32  number of committed instructions

Behaviour:
- Reset (iRST=0, asynchronous): all outputs and counters are 0; edge-detect registers are 0; mode=RUN; skipBrk=1.
  - State goes to HALTED, or to FETCH when START_RUNNING=1.
- Edge detection: evX = iX & ~prevX, with prevX registered every cycle. Inputs are already synchronous to iCLK.
- Outputs are Moore: oCpuEn = (state==EXEC), oDone = (state==DONE), both registered, glitch-free.
- HALTED:
  - evRun -> FETCH, mode=RUN.
  - Otherwise evStep -> FETCH, mode=STEP. Run wins if both occur in the same cycle.
  - evHalt is ignored.
  - On leaving: skipBrk=1 and oBreakHit=0.
- FETCH:
  - The wait counter loads 0 on entry and increments each cycle.
  - evHalt in any FETCH cycle -> HALTED; the instruction is not committed.
  - When the counter reaches FETCH_WAIT-1, evaluate in this order:
    1. iInstruction==ECALL_WORD -> DONE.
    2. iBreakEn & iPC==iBreakAddr & !skipBrk -> HALTED, oBreakHit=1.
    3. Otherwise -> EXEC.
  - FETCH therefore lasts exactly FETCH_WAIT cycles when uninterrupted.
- EXEC:
  - Lasts exactly one cycle with oCpuEn=1; oInstrCount+1; skipBrk=0.
  - Next state is HALTED if mode=STEP or evHalt occurs this cycle (the instruction still commits); otherwise FETCH.
- DONE: terminal; only reset exits. oCpuEn stays 0 and counters freeze.
- oCycleCount increments in every FETCH or EXEC cycle; it holds in HALTED and DONE.
- Both counters wrap modulo 2^32.
- Per-instruction latency in RUN mode is FETCH_WAIT+1 cycles: FETCH_WAIT=1 gives one commit every 2 cycles.
- The breakpoint is checked before commit, so the breakpoint instruction is never executed on hit.
- The first instruction after any resume skips the breakpoint check, so resuming makes progress.
- Reset asserted mid-EXEC: oCpuEn drops immediately (asynchronous).
- The datapath's own reset PC (0x0040_0000) is independent of this block.

Test Plan:
- Reset release, START_RUNNING=0, no inputs for 20 cycles -> oState=0, oCpuEn=0, oCycleCount=0.
- iRun rises, FETCH_WAIT=1, ROM of NOPs -> oCpuEn pulses on every 2nd cycle; after 10 cycles oInstrCount=5, oCycleCount=10.
- From HALTED, iStep rises once, FETCH_WAIT=3 -> exactly one oCpuEn pulse 3 cycles after the edge, oInstrCount=1, back to HALTED.
  - Holding iStep high causes no second step.
- iBreakEn=1, iBreakAddr=0x0040_0003, run from 0x0040_0000 -> 3 commits, then HALTED with oBreakHit=1 and iPC=0x0040_0003.
  - A following iRun commits 0x0040_0003 and continues.
- Instruction 0x0000_0073 fetched at the 4th PC -> oState=3, oDone=1, oInstrCount=3.
  - iRun/iStep are ignored afterwards; only an iRST low pulse clears the stop.
- iHalt edge during FETCH -> HALTED with no commit.
- iHalt edge during EXEC -> that commit occurs, then HALTED.
- iRun and iStep rise in the same cycle -> continuous RUN.

Source files
------------

// File: rtl/cpu_exec_ctrl.sv
// Execution sequencer for the single-cycle RISC-V datapath: gates commits,
// waits out ROM latency, and handles run/step/halt, breakpoint and ECALL stop.
module cpu_exec_ctrl #(
  parameter int          FETCH_WAIT    = 1,
  parameter bit          START_RUNNING = 1'b0,
  parameter logic [31:0] ECALL_WORD    = 32'h0000_0073
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRun,
  input  logic        iStep,
  input  logic        iHalt,
  input  logic        iBreakEn,
  input  logic [31:0] iBreakAddr,
  input  logic [31:0] iPC,
  input  logic [31:0] iInstruction,
  output logic        oCpuEn,
  output logic [1:0]  oState,
  output logic        oBreakHit,
  output logic        oDone,
  output logic [31:0] oCycleCount,
  output logic [31:0] oInstrCount
);

  typedef enum logic [1:0] {HALTED = 2'd0, FETCH = 2'd1, EXEC = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT - 1);

  state_t     state, stateNxt;
  logic       modeStep, modeStepNxt;
  logic       skipBrk, skipBrkNxt;
  logic       breakHitNxt;
  logic [3:0] waitCnt;
  logic       prevRun, prevStep, prevHalt;
  logic       evRun, evStep, evHalt;

  assign evRun  = iRun  & ~prevRun;
  assign evStep = iStep & ~prevStep;
  assign evHalt = iHalt & ~prevHalt;
  assign oState = state;

  always_comb begin
    stateNxt    = state;
    modeStepNxt = modeStep;
    skipBrkNxt  = skipBrk;
    breakHitNxt = oBreakHit;
    case (state)
      HALTED: begin
        if (evRun || evStep) begin
          stateNxt    = FETCH;
          modeStepNxt = ~evRun;
          skipBrkNxt  = 1'b1;
          breakHitNxt = 1'b0;
        end
      end
      FETCH: begin
        if (evHalt) begin
          stateNxt = HALTED;
        end else if (waitCnt == WAIT_LAST) begin
          if (iInstruction == ECALL_WORD) begin
            stateNxt = DONE;
          end else if (iBreakEn && (iPC == iBreakAddr) && !skipBrk) begin
            stateNxt    = HALTED;
            breakHitNxt = 1'b1;
          end else begin
            stateNxt = EXEC;
          end
        end
      end
      // The instruction commits even if a halt arrives in this cycle.
      EXEC: begin
        skipBrkNxt = 1'b0;
        stateNxt   = (modeStep || evHalt) ? HALTED : FETCH;
      end
      default: stateNxt = DONE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= START_RUNNING ? FETCH : HALTED;
      modeStep    <= 1'b0;
      skipBrk     <= 1'b1;
      oBreakHit   <= 1'b0;
      oCpuEn      <= 1'b0;
      oDone       <= 1'b0;
      waitCnt     <= '0;
      prevRun     <= 1'b0;
      prevStep    <= 1'b0;
      prevHalt    <= 1'b0;
      oCycleCount <= '0;
      oInstrCount <= '0;
    end else begin
      state     <= stateNxt;
      modeStep  <= modeStepNxt;
      skipBrk   <= skipBrkNxt;
      oBreakHit <= breakHitNxt;
      oCpuEn    <= (stateNxt == EXEC);
      oDone     <= (stateNxt == DONE);
      prevRun   <= iRun;
      prevStep  <= iStep;
      prevHalt  <= iHalt;
      // Any non-FETCH cycle clears the wait counter, so every FETCH entry starts at 0.
      waitCnt   <= (state == FETCH) ? waitCnt + 4'd1 : 4'd0;
      if (state == FETCH || state == EXEC) oCycleCount <= oCycleCount + 32'd1;
      if (state == EXEC)                   oInstrCount <= oInstrCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl: a tiny PC/ROM model drives the main
// instance; side instances cover FETCH_WAIT=3 stepping and START_RUNNING=1.
module tb_cpu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0, step = 1'b0, halt = 1'b0, brkEn = 1'b0;
  logic [31:0] brkAddr = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  bit          ecallOn = 1'b0;

  logic        cpuEn, brkHit, done;
  logic [1:0]  st;
  logic [31:0] cyc, ic;

  logic        step3 = 1'b0;
  logic        cpuEn3, brkHit3, done3;
  logic [1:0]  st3;
  logic [31:0] cyc3, ic3;

  logic        cpuEnS, brkHitS, doneS;
  logic [1:0]  stS;
  logic [31:0] cycS, icS;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst)       pc <= 32'h0040_0000;
    else if (cpuEn) pc <= pc + 32'd1;

  assign instr = (ecallOn && pc == 32'h0040_0003) ? 32'h0000_0073 : 32'h0000_0013;

  cpu_exec_ctrl #(.FETCH_WAIT(1)) dut (
    .iCLK(clk), .iRST(rst), .iRun(run), .iStep(step), .iHalt(halt),
    .iBreakEn(brkEn), .iBreakAddr(brkAddr), .iPC(pc), .iInstruction(instr),
    .oCpuEn(cpuEn), .oState(st), .oBreakHit(brkHit), .oDone(done),
    .oCycleCount(cyc), .oInstrCount(ic));

  cpu_exec_ctrl #(.FETCH_WAIT(3)) dut3 (
    .iCLK(clk), .iRST(rst), .iRun(1'b0), .iStep(step3), .iHalt(1'b0),
    .iBreakEn(1'b0), .iBreakAddr(32'h0), .iPC(32'h0), .iInstruction(32'h13),
    .oCpuEn(cpuEn3), .oState(st3), .oBreakHit(brkHit3), .oDone(done3),
    .oCycleCount(cyc3), .oInstrCount(ic3));

  cpu_exec_ctrl #(.FETCH_WAIT(1), .START_RUNNING(1'b1)) dutS (
    .iCLK(clk), .iRST(rst), .iRun(1'b0), .iStep(1'b0), .iHalt(1'b0),
    .iBreakEn(1'b0), .iBreakAddr(32'h0), .iPC(32'h0), .iInstruction(32'h13),
    .oCpuEn(cpuEnS), .oState(stS), .oBreakHit(brkHitS), .oDone(doneS),
    .oCycleCount(cycS), .oInstrCount(icS));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rstPulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int n;
    logic [31:0] cycFrozen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(st), 32'd0);
    check("rst_cpuen", 32'(cpuEn), 32'd0);
    check("rst_cyc", cyc, 32'd0);
    check("rst_startrun_state", 32'(stS), 32'd1);
    rst = 1'b1;
    tick(20);
    check("idle_state", 32'(st), 32'd0);
    check("idle_cpuen", 32'(cpuEn), 32'd0);
    check("idle_cyc", cyc, 32'd0);
    check("startrun_ic", icS, 32'd10);
    check("startrun_cyc", cycS, 32'd20);

    // Continuous run, FETCH_WAIT=1: commit every second cycle
    run = 1'b1;
    tick();
    check("run_enter", 32'(st), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("run_cpuen_%0d", k), 32'(cpuEn), 32'(k % 2));
    end
    check("run_ic", ic, 32'd5);
    check("run_cyc", cyc, 32'd10);
    // Halt edge in FETCH: no commit
    check("halt_pre_fetch", 32'(st), 32'd1);
    halt = 1'b1;
    tick();
    check("haltf_state", 32'(st), 32'd0);
    check("haltf_ic", ic, 32'd5);
    check("haltf_pc", pc, 32'h0040_0005);
    run = 1'b0; halt = 1'b0;
    tick();

    // Single step on FETCH_WAIT=3, iStep held high
    step3 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("step3_cpuen_%0d", k), 32'(cpuEn3), (k == 4) ? 32'd1 : 32'd0);
    end
    tick(4);
    check("step3_ic", ic3, 32'd1);
    check("step3_state", 32'(st3), 32'd0);
    check("step3_cyc", cyc3, 32'd4);
    step3 = 1'b0;

    // Breakpoint at 0x0040_0003
    rstPulse();
    tick();
    brkEn = 1'b1; brkAddr = 32'h0040_0003; run = 1'b1;
    tick();
    n = 0;
    while (st !== 2'd0 && n < 40) begin tick(); n++; end
    check("brk_state", 32'(st), 32'd0);
    check("brk_hit", 32'(brkHit), 32'd1);
    check("brk_ic", ic, 32'd3);
    check("brk_pc", pc, 32'h0040_0003);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick(3);
    check("resume_hit_clr", 32'(brkHit), 32'd0);
    check("resume_ic", ic, 32'd4);
    check("resume_pc", pc, 32'h0040_0004);
    check("resume_state", 32'(st), 32'd1);
    // Halt edge in EXEC: commit still happens
    tick();
    check("haltx_pre_cpuen", 32'(cpuEn), 32'd1);
    halt = 1'b1;
    tick();
    check("haltx_state", 32'(st), 32'd0);
    check("haltx_ic", ic, 32'd5);
    check("haltx_pc", pc, 32'h0040_0005);
    run = 1'b0; halt = 1'b0; brkEn = 1'b0;
    tick();
    halt = 1'b1;
    tick(2);
    check("halt_in_halted", 32'(st), 32'd0);
    halt = 1'b0;
    tick();

    // Run and step together: run wins
    run = 1'b1; step = 1'b1;
    tick(5);
    check("runstep_ic", ic, 32'd7);
    check("runstep_state", 32'(st), 32'd1);
    halt = 1'b1;
    tick();
    run = 1'b0; step = 1'b0; halt = 1'b0;
    tick();

    // Asynchronous reset mid-EXEC
    run = 1'b1;
    tick(2);
    check("arst_pre_cpuen", 32'(cpuEn), 32'd1);
    rst = 1'b0;
    #2;
    check("arst_cpuen", 32'(cpuEn), 32'd0);
    check("arst_state", 32'(st), 32'd0);
    run = 1'b0; ecallOn = 1'b1;
    tick();
    rst = 1'b1;
    tick();

    // ECALL at the 4th PC
    run = 1'b1;
    tick();
    n = 0;
    while (st !== 2'd3 && n < 40) begin tick(); n++; end
    check("ecall_state", 32'(st), 32'd3);
    check("ecall_done", 32'(done), 32'd1);
    check("ecall_ic", ic, 32'd3);
    check("ecall_cyc", cyc, 32'd7);
    cycFrozen = cyc;
    run = 1'b0; tick(); run = 1'b1; step = 1'b1; tick(); step = 1'b0; tick(3);
    check("done_state", 32'(st), 32'd3);
    check("done_cpuen", 32'(cpuEn), 32'd0);
    check("done_ic", ic, 32'd3);
    check("done_cyc", cyc, cycFrozen);
    run = 1'b0; ecallOn = 1'b0;
    rstPulse();
    tick();
    check("done_clr_state", 32'(st), 32'd0);
    check("done_clr_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
